alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept strobe, one-hot or zero.
REQ-006 req0_op1, req0_op2  input  WIDTH each  requester 0 operands.
REQ-007 req0_alu_op  input  4  requester 0 opcode.
REQ-008 req1_op1, req1_op2  input  WIDTH each  requester 1 operands.
REQ-009 req1_alu_op  input  4  requester 1 opcode.
REQ-010 alu_op1, alu_op2  output  WIDTH each  operands to shared combinational ALU.
REQ-011 alu_op  output  4  opcode to shared ALU.
REQ-012 alu_result  input  WIDTH  ALU result.
REQ-013 alu_zero, alu_carry_out, alu_overflow  input  1 each  ALU flags.
REQ-014 rsp_valid  output  1  response valid.
REQ-015 rsp_ready  input  1  response consumer ready.
REQ-016 rsp_id  output  1  index of requester owning the response.
REQ-017 rsp_result  output  WIDTH  captured result.
REQ-018 rsp_zero, rsp_carry_out, rsp_overflow  output  1 each  captured flags.
REQ-019 rsp_err  output  1  illegal opcode indicator.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 Opcode map SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001; 1010-1111 illegal.
REQ-022 FSM SHALL have states IDLE, EXEC, RESP; one transaction in flight at most.
REQ-023 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally that cycle, latch its operands/opcode/id into internal registers, go to EXEC; else stay IDLE.
REQ-024 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester other than last_grant wins; last_grant updates on every accept.
REQ-025 req_ready SHALL be zero in EXEC and RESP and when req_valid is zero.
REQ-026 alu_op1/alu_op2/alu_op SHALL be driven from the latched registers only (never directly from request inputs); legal ops drive the latched opcode, illegal ops drive 0000.
REQ-027 EXEC: exactly one cycle; at its end capture alu_result and flags into rsp registers, set rsp_err for illegal opcode, go to RESP.
REQ-028 Illegal opcode SHALL yield rsp_result=0, rsp_zero=0, rsp_carry_out=0, rsp_overflow=0, rsp_err=1.
REQ-029 RESP: rsp_valid=1 with all rsp_* stable; on rsp_valid&&rsp_ready return to IDLE; otherwise hold indefinitely.
REQ-030 Latency: request accepted on edge N -> rsp_valid high from edge N+2; minimum 3 cycles between accepts (back-to-back with rsp_ready held high).
REQ-031 rsp_valid SHALL be zero in IDLE and EXEC; rsp_* data may hold last values when rsp_valid=0.
REQ-032 Requests arriving in EXEC/RESP SHALL wait (not dropped); requester must hold req_valid and operands until req_ready.

Reset
REQ-033 rst high on a clk edge SHALL force state IDLE, last_grant=1 (so requester 0 wins first tie), all latched and rsp registers 0, rsp_valid=0, busy=0.
REQ-034 Reset during EXEC or RESP SHALL discard the in-flight transaction with no response issued.
REQ-035 req_ready SHALL be 0 in any cycle rst is high.

Verification
REQ-036 req0 ADD op1=10, op2=5, rsp_ready=1 -> rsp_valid at accept+2, rsp_id=0, rsp_result=15, rsp_zero=0, rsp_err=0.
REQ-037 After reset both valid (req0 SUB 10,5; req1 AND 10,5) -> req0 granted first (result 5), req1 next (result 0, rsp_zero=1), rsp_id 0 then 1.
REQ-038 Both held valid continuously, 4 transactions -> grants alternate 0,1,0,1.
REQ-039 rsp_ready low 3 cycles in RESP -> rsp_valid and all rsp_* stable, req_ready stays 0, release completes one transfer.
REQ-040 req1 opcode 1100 -> rsp_err=1, rsp_result=0, all flags 0, alu_op driven 0000.
REQ-041 rst asserted during EXEC -> next cycle state IDLE, busy=0, rsp_valid=0, and no response for dropped transaction ever appears.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU, one transaction at a time.
// Latency: accept on edge N, rsp_valid from edge N+2; rsp_valid holds until rsp_ready, and requests wait while busy.
// Backpressure: req_ready is 0 while busy, in reset or without req_valid; the response holds while rsp_ready is low.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [3:0]       req0_alu_op,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [3:0]       req1_alu_op,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry_out,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry_out,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [3:0]       op_q, op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_err_q, rsp_err_d;

    logic op_legal;
    logic grant;

    assign op_legal = (op_q <= 4'd9);
    // On a tie the requester that did not win last time goes next.
    assign grant    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        op_d         = op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = 2'b00;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready    = grant ? 2'b10 : 2'b01;
                    last_grant_d = grant;
                    id_d         = grant;
                    op1_d        = grant ? req1_op1    : req0_op1;
                    op2_d        = grant ? req1_op2    : req0_op2;
                    op_d         = grant ? req1_alu_op : req0_alu_op;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d     = id_q;
                rsp_result_d = op_legal ? alu_result    : '0;
                rsp_zero_d   = op_legal ? alu_zero      : 1'b0;
                rsp_carry_d  = op_legal ? alu_carry_out : 1'b0;
                rsp_ovf_d    = op_legal ? alu_overflow  : 1'b0;
                rsp_err_d    = ~op_legal;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req_ready = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            op_q         <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            op_q         <= op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // The ALU sees only latched operands; illegal opcodes are neutralised to ADD.
    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign alu_op        = op_legal ? op_q : 4'b0000;
    assign rsp_valid     = (state_q == RESP);
    assign busy          = (state_q != IDLE);
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_carry_out = rsp_carry_q;
    assign rsp_overflow  = rsp_ovf_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter with a queue-based scoreboard and a reference ALU/arbiter model.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] r_a [2];
    logic [W-1:0] r_b [2];
    logic [3:0]   r_op [2];
    logic [W-1:0] alu_op1, alu_op2, alu_result, rsp_result;
    logic [3:0]   alu_op;
    logic         alu_zero, alu_carry_out, alu_overflow;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry_out, rsp_overflow, rsp_err, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op1(r_a[0]), .req0_op2(r_b[0]), .req0_alu_op(r_op[0]),
        .req1_op1(r_a[1]), .req1_op2(r_b[1]), .req1_alu_op(r_op[1]),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry_out(alu_carry_out),
        .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_carry_out(rsp_carry_out), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
        .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z, c, v;
    } alu_t;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         z, c, v, err;
        logic [3:0]   aop;
        logic [W-1:0] a, b;
        logic [31:0]  acc;
    } exp_t;

    function automatic alu_t alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_t r;
        logic [W:0] w;
        r = '0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r.res = w[W-1:0]; r.c = w[W];
                        r.v = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r.res = w[W-1:0]; r.c = w[W];
                        r.v = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]); end
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = a ^ b;
            4'd5: r.res = a << b[4:0];
            4'd6: r.res = a >> b[4:0];
            4'd7: r.res = W'($signed(a) >>> b[4:0]);
            4'd8: r.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd9: r.res = (a < b) ? W'(1) : W'(0);
            default: r.res = '0;
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    // External combinational ALU driven by the DUT
    alu_t alu_r;
    always_comb alu_r = alu_f(alu_op, alu_op1, alu_op2);
    assign alu_result    = alu_r.res;
    assign alu_zero      = alu_r.z;
    assign alu_carry_out = alu_r.c;
    assign alu_overflow  = alu_r.v;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    exp_t q[$];
    logic lg = 1'b1;
    logic in_flight = 1'b0;
    logic prev_hold = 1'b0;
    logic [63:0] prev_bundle = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: reference arbiter/ALU model pushes expectations on accept, response side pops and compares.
    always @(negedge clk) begin
        logic inf0, w;
        exp_t e;
        alu_t m;
        inf0 = in_flight;
        if (rst) begin
            check("ready_in_reset", {62'b0, req_ready}, 64'd0);
            lg = 1'b1; in_flight = 1'b0; prev_hold = 1'b0; q.delete();
        end else begin
            check("busy", {63'b0, busy}, {63'b0, inf0});
            if (inf0 || req_valid == 2'b00) begin
                check("ready_zero", {62'b0, req_ready}, 64'd0);
            end else begin
                w = (req_valid == 2'b11) ? ~lg : req_valid[1];
                check("grant", {62'b0, req_ready}, w ? 64'd2 : 64'd1);
                m = alu_f(r_op[w], r_a[w], r_b[w]);
                e.id = w; e.a = r_a[w]; e.b = r_b[w];
                e.err = (r_op[w] > 4'd9);
                e.aop = e.err ? 4'd0 : r_op[w];
                e.res = e.err ? '0 : m.res;
                e.z = e.err ? 1'b0 : m.z;
                e.c = e.err ? 1'b0 : m.c;
                e.v = e.err ? 1'b0 : m.v;
                e.acc = cyc;
                q.push_back(e);
                lg = w; in_flight = 1'b1;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_without_req", {63'b0, rsp_valid}, 64'd0);
                end else begin
                    e = q[0];
                    if (!prev_hold) check("latency", 64'(cyc - int'(e.acc)), 64'd2);
                    else check("rsp_stable", {27'b0, rsp_id, rsp_result, rsp_zero, rsp_carry_out, rsp_overflow, rsp_err}, prev_bundle);
                    if (rsp_ready) begin
                        check("rsp_id", {63'b0, rsp_id}, {63'b0, e.id});
                        check("rsp_result", {32'b0, rsp_result}, {32'b0, e.res});
                        check("rsp_flags", {60'b0, rsp_zero, rsp_carry_out, rsp_overflow, rsp_err}, {60'b0, e.z, e.c, e.v, e.err});
                        void'(q.pop_front());
                        in_flight = 1'b0;
                    end
                end
            end else if (busy && q.size() != 0) begin
                e = q[0];
                check("exec_alu_op", {60'b0, alu_op}, {60'b0, e.aop});
                check("exec_operands", {alu_op1, alu_op2}, {e.a, e.b});
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_bundle = {27'b0, rsp_id, rsp_result, rsp_zero, rsp_carry_out, rsp_overflow, rsp_err};
        end
    end

    // Stimulus
    int         mode = 0;   // 0: drop on accept, 1: reissue on accept, 2: random
    int         n_acc = 0;
    logic [1:0] last_tk = '0;

    task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        r_op[i] = op; r_a[i] = a; r_b[i] = b; req_valid[i] = 1'b1;
    endtask

    task automatic rand_req(input int i, input int max_op);
        set_req(i, 4'($urandom_range(0, max_op)), $urandom,
                ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom));
    endtask

    task automatic step();
        logic [1:0] tk;
        @(negedge clk);
        tk = req_ready;
        @(posedge clk);
        #1;
        last_tk = tk;
        n_acc += $countones(tk);
        for (int i = 0; i < 2; i++) begin
            if (tk[i]) begin
                if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 0)) rand_req(i, 9);
                else req_valid[i] = 1'b0;
            end else if (mode == 2 && !req_valid[i] && $urandom_range(0, 2) == 0) begin
                rand_req(i, 15);
            end
        end
        if (mode == 2) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            done = (req_valid == 2'b00) && !busy && (q.size() == 0);
        end
        check("drain_timeout", {63'b0, done}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin r_a[i] = '0; r_b[i] = '0; r_op[i] = '0; end
        do_reset();
        @(negedge clk);
        check("reset_state", {busy, rsp_valid, rsp_err, rsp_result, alu_op}, 64'd0);
        check("reset_alu_operands", {alu_op1, alu_op2}, 64'd0);

        // Single ADD from requester 0
        rsp_ready = 1'b1;
        set_req(0, 4'd0, 32'd10, 32'd5);
        wait_idle(20);

        // Tie straight out of reset: requester 0 first, then 1
        set_req(0, 4'd1, 32'd10, 32'd5);
        set_req(1, 4'd2, 32'd10, 32'd5);
        do_reset();
        wait_idle(20);

        // Both held valid continuously: grants alternate
        mode = 1; n_acc = 0;
        rand_req(0, 9); rand_req(1, 9);
        for (int k = 0; k < 40 && n_acc < 4; k++) step();
        check("alternate_count", 64'(n_acc), 64'd4);
        mode = 0;
        wait_idle(30);

        // Response backpressure for three cycles
        rsp_ready = 1'b0;
        set_req(0, 4'd4, 32'hdead_beef, 32'h1234_5678);
        for (int k = 0; k < 10 && !rsp_valid; k++) step();
        set_req(1, 4'd3, 32'h0f0f_0000, 32'h0000_f0f0);
        step(); step(); step();
        rsp_ready = 1'b1;
        wait_idle(30);

        // Illegal opcode from requester 1
        set_req(1, 4'b1100, 32'hffff_ffff, 32'd7);
        wait_idle(20);

        // Reset while the transaction is in EXEC
        set_req(0, 4'd0, 32'd1, 32'd2);
        last_tk = '0;
        for (int k = 0; k < 10 && last_tk == 2'b00; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {63'b0, busy}, 64'd0);
        check("post_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        repeat (8) step();

        // Random traffic with random backpressure
        mode = 2;
        repeat (400) step();
        mode = 0; rsp_ready = 1'b1;
        wait_idle(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
